// File: rtl/peripheral_dbg_soc_ctm_arb_pkg.sv
// Shared types for the CTM trace arbiter: trace event record and round-robin pick helper.
// Events carry a 32-bit pc/npc; narrower ADDR_WIDTH builds zero-extend into it.
package peripheral_dbg_soc_ctm_arb_pkg;

  localparam int CTM_ADDR_W = 32;

  typedef struct packed {
    logic [CTM_ADDR_W-1:0] pc;
    logic [CTM_ADDR_W-1:0] npc;
    logic                  jal;
    logic                  jalr;
  } trace_evt_t;

  // Returns {found, index} of the first set req bit at or after ptr, wrapping at n (n <= 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[3'(idx)]) res = {1'b1, 3'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/peripheral_dbg_soc_osd_ctm_trace_fifo.sv
// Per-core synchronous FIFO of trace events; pop data is combinational from the head entry.
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle; flush empties it.
module peripheral_dbg_soc_osd_ctm_trace_fifo
  import peripheral_dbg_soc_ctm_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  trace_evt_t push_dat,
  input  logic       pop,
  output trace_evt_t pop_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  trace_evt_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/peripheral_dbg_soc_osd_ctm_trace_arb.sv
// Round-robin merge of NUM_CORES trace streams into one registered CTM port; 2-cycle idle latency.
// No backpressure: full FIFOs drop new events, counted per core when CTM_ARB_OVF_CNT_EN is defined.
module peripheral_dbg_soc_osd_ctm_trace_arb
  import peripheral_dbg_soc_ctm_arb_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            in_valid,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] in_pc,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] in_npc,
  input  logic [NUM_CORES-1:0]            in_jal,
  input  logic [NUM_CORES-1:0]            in_jalr,
  input  logic [NUM_CORES-1:0]            cfg_core_en,
  input  logic                            cfg_clr,
  output logic                            out_valid,
  output logic [ADDR_WIDTH-1:0]           out_pc,
  output logic [ADDR_WIDTH-1:0]           out_npc,
  output logic                            out_jal,
  output logic                            out_jalr,
  output logic [$clog2(NUM_CORES)-1:0]    out_core_id,
  output logic [NUM_CORES*16-1:0]         ovf_cnt
);

  localparam int CW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] full, empty, push, pop;
  trace_evt_t           fifo_dat [NUM_CORES];
  trace_evt_t           sel_evt;
  logic [3:0]           pick;
  logic                 gnt_vld;

  logic                 out_valid_q, out_valid_d;
  trace_evt_t           out_evt_q, out_evt_d;
  logic [CW-1:0]        out_core_id_q, out_core_id_d;
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    trace_evt_t evt;

    always_comb begin
      evt.pc   = CTM_ADDR_W'(in_pc[i*ADDR_WIDTH +: ADDR_WIDTH]);
      evt.npc  = CTM_ADDR_W'(in_npc[i*ADDR_WIDTH +: ADDR_WIDTH]);
      evt.jal  = in_jal[i];
      evt.jalr = in_jalr[i];
    end

    assign push[i] = in_valid[i] & cfg_core_en[i] & (~full[i] | pop[i]);
    assign pop[i]  = gnt_vld && (pick[2:0] == 3'(i));

    peripheral_dbg_soc_osd_ctm_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (cfg_clr),
      .push     (push[i]),
      .push_dat (evt),
      .pop      (pop[i]),
      .pop_dat  (fifo_dat[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );
  end

  // A clear wins over the grant, so nothing is popped and the RR pointer holds.
  assign pick    = rr_pick(8'(~empty), 3'(rr_ptr_q), NUM_CORES);
  assign gnt_vld = pick[3] & ~cfg_clr;

  always_comb begin
    sel_evt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pop[i]) sel_evt = fifo_dat[i];
    end
  end

  always_comb begin
    out_valid_d   = 1'b0;
    out_evt_d     = out_evt_q;
    out_core_id_d = out_core_id_q;
    rr_ptr_d      = rr_ptr_q;
    if (cfg_clr) begin
      out_evt_d     = '0;
      out_core_id_d = '0;
    end else if (gnt_vld) begin
      out_valid_d   = 1'b1;
      out_evt_d     = sel_evt;
      out_core_id_d = CW'(pick[2:0]);
      rr_ptr_d      = (pick[2:0] == 3'(NUM_CORES-1)) ? '0 : CW'(pick[2:0] + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_evt_q     <= '0;
      out_core_id_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_evt_q     <= out_evt_d;
      out_core_id_q <= out_core_id_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_evt_q.pc[ADDR_WIDTH-1:0];
  assign out_npc     = out_evt_q.npc[ADDR_WIDTH-1:0];
  assign out_jal     = out_evt_q.jal;
  assign out_jalr    = out_evt_q.jalr;
  assign out_core_id = out_core_id_q;

`ifdef CTM_ARB_OVF_CNT_EN
  logic [NUM_CORES*16-1:0] ovf_cnt_q, ovf_cnt_d;

  // An enabled event that was not pushed is exactly a drop on a full FIFO.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (cfg_clr) begin
      ovf_cnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (in_valid[i] && cfg_core_en[i] && !push[i] && ovf_cnt_q[i*16 +: 16] != 16'hFFFF)
          ovf_cnt_d[i*16 +: 16] = ovf_cnt_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_ctm_trace_arb.sv
// Self-checking bench for the CTM trace arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_peripheral_dbg_soc_osd_ctm_trace_arb;

  localparam int NC    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [NC-1:0] in_valid;
  logic [63:0]   in_pc;
  logic [63:0]   in_npc;
  logic [NC-1:0] in_jal;
  logic [NC-1:0] in_jalr;
  logic [NC-1:0] cfg_core_en;
  logic          cfg_clr;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_npc;
  logic          out_jal;
  logic          out_jalr;
  logic [0:0]    out_core_id;
  logic [31:0]   ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [65:0] mq [NC][$];
  int          m_ptr;
  logic        m_vld;
  logic        m_core;
  logic [65:0] m_dat;
  logic [15:0] m_ovf [NC];
  int          m_drops;

  int obs_outs;
  int obs_c1;
  int last_core;
  int alt_bad;

  peripheral_dbg_soc_osd_ctm_trace_arb #(
    .NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_npc(in_npc),
    .in_jal(in_jal), .in_jalr(in_jalr), .cfg_core_en(cfg_core_en), .cfg_clr(cfg_clr),
    .out_valid(out_valid), .out_pc(out_pc), .out_npc(out_npc), .out_jal(out_jal),
    .out_jalr(out_jalr), .out_core_id(out_core_id), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [67:0] obs();
    return {out_valid, out_core_id, out_pc, out_npc, out_jal, out_jalr};
  endfunction

  function automatic logic [67:0] expv();
    return {m_vld, m_core, m_dat};
  endfunction

  function automatic logic [31:0] exp_ovf();
`ifdef CTM_ARB_OVF_CNT_EN
    return {m_ovf[1], m_ovf[0]};
`else
    return 32'd0;
`endif
  endfunction

  // One clock of the arbiter's rules: pop first (frees a slot), then accept/drop pushes.
  task automatic model_step();
    int g;
    if (rst || cfg_clr) begin
      for (int c = 0; c < NC; c++) begin
        mq[c].delete();
        m_ovf[c] = 16'd0;
      end
      if (rst) m_ptr = 0;
      m_vld  = 1'b0;
      m_core = 1'b0;
      m_dat  = '0;
    end else begin
      g = -1;
      for (int k = 0; k < NC; k++) begin
        if (g < 0 && mq[(m_ptr + k) % NC].size() > 0) g = (m_ptr + k) % NC;
      end
      if (g >= 0) begin
        m_dat  = mq[g].pop_front();
        m_vld  = 1'b1;
        m_core = g[0];
        m_ptr  = (g + 1) % NC;
      end else begin
        m_vld = 1'b0;
      end
      for (int c = 0; c < NC; c++) begin
        if (in_valid[c] && cfg_core_en[c]) begin
          if (mq[c].size() < DEPTH) begin
            mq[c].push_back({in_pc[c*32 +: 32], in_npc[c*32 +: 32], in_jal[c], in_jalr[c]});
          end else begin
            m_drops++;
            if (m_ovf[c] != 16'hFFFF) m_ovf[c] = m_ovf[c] + 16'd1;
          end
        end
      end
    end
  endtask

  task automatic drive_rand(input logic [NC-1:0] vld);
    in_valid = vld;
    in_pc    = {$urandom, $urandom};
    in_npc   = {$urandom, $urandom};
    in_jal   = NC'($urandom);
    in_jalr  = NC'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); model_step(); #1;
    end
    n_tests++;
    if (obs() !== 68'd0) begin
      n_fail++; $display("FAIL reset_out: got %h want 0", obs());
    end
    n_tests++;
    if (ovf_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_ovf: got %h want 0", ovf_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 2'b01; in_pc = 64'h1000; in_npc = 64'h2000; in_jal = 2'b01; in_jalr = 2'b00;
    @(posedge clk); model_step(); #1;
    in_valid = '0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_t1: out_valid got %b want 0", out_valid);
    end
    @(posedge clk); model_step(); #1;
    n_tests++;
    if ({out_valid, out_core_id, out_pc, out_npc, out_jal, out_jalr} !==
        {1'b1, 1'b0, 32'h1000, 32'h2000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_t2: got %h want valid core0 pc 1000 npc 2000 jal", obs());
    end
    repeat (2) begin
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL single_idle: got %h want %h", obs(), expv());
      end
    end
  endtask

  task automatic test_alternate();
    obs_outs = 0; last_core = -1; alt_bad = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 4) drive_rand(2'b11); else in_valid = '0;
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL alt_out: got %h want %h", obs(), expv());
      end
      if (out_valid) begin
        obs_outs++;
        if (last_core == int'(out_core_id)) alt_bad++;
        last_core = int'(out_core_id);
      end
    end
    n_tests++;
    if (obs_outs != 8 || alt_bad != 0) begin
      n_fail++; $display("FAIL alt_count: got %0d events %0d repeats want 8 events 0 repeats", obs_outs, alt_bad);
    end
    n_tests++;
    if (ovf_cnt !== 32'd0) begin
      n_fail++; $display("FAIL alt_ovf: got %h want 0", ovf_cnt);
    end
  endtask

  task automatic test_core1_burst();
    obs_outs = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive_rand(2'b10); else in_valid = '0;
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL burst_out: got %h want %h", obs(), expv());
      end
      if (out_valid) obs_outs++;
    end
    n_tests++;
    if (obs_outs != 8 || ovf_cnt[31:16] !== 16'd0) begin
      n_fail++; $display("FAIL burst_count: got %0d events ovf1 %0d want 8 events ovf1 0", obs_outs, ovf_cnt[31:16]);
    end
  endtask

  task automatic test_overload();
    obs_outs = 0; m_drops = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc < 12) drive_rand(2'b11); else in_valid = '0;
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL ovl_out: got %h want %h", obs(), expv());
      end
      if (out_valid) obs_outs++;
    end
    n_tests++;
    if (obs_outs + m_drops != 24 || m_drops == 0) begin
      n_fail++; $display("FAIL ovl_sum: got %0d events + %0d drops want 24 with drops", obs_outs, m_drops);
    end
    n_tests++;
    if (ovf_cnt !== exp_ovf()) begin
      n_fail++; $display("FAIL ovl_ovf: got %h want %h", ovf_cnt, exp_ovf());
    end
  endtask

  task automatic test_core_en();
    obs_outs = 0; obs_c1 = 0;
    cfg_core_en = 2'b01;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 6) drive_rand(2'b11); else in_valid = '0;
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL en_out: got %h want %h", obs(), expv());
      end
      if (out_valid) begin
        obs_outs++;
        if (out_core_id == 1'b1) obs_c1++;
      end
    end
    n_tests++;
    if (obs_outs != 6 || obs_c1 != 0 || ovf_cnt[31:16] !== 16'd0) begin
      n_fail++; $display("FAIL en_filter: got %0d events %0d from core1 ovf1 %0d want 6 0 0", obs_outs, obs_c1, ovf_cnt[31:16]);
    end
    cfg_core_en = 2'b11;
  endtask

  task automatic test_clr();
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive_rand(2'b11);
      @(posedge clk); model_step(); #1;
    end
    in_valid = '0; cfg_clr = 1'b1;
    @(posedge clk); model_step(); #1;
    cfg_clr = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || ovf_cnt !== 32'd0) begin
      n_fail++; $display("FAIL clr_next: got valid %b ovf %h want 0 0", out_valid, ovf_cnt);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL clr_empty: out_valid got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_rst_mid();
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive_rand(2'b11);
      @(posedge clk); model_step(); #1;
    end
    rst = 1'b1;
    @(posedge clk); model_step(); #1;
    rst = 1'b0; in_valid = '0;
    n_tests++;
    if (obs() !== 68'd0 || ovf_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid: got %h ovf %h want 0", obs(), ovf_cnt);
    end
    repeat (2) begin
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_empty: out_valid got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 500; cyc++) begin
      drive_rand(NC'($urandom));
      cfg_core_en = ($urandom_range(0, 9) < 8) ? 2'b11 : NC'($urandom);
      cfg_clr     = ($urandom_range(0, 49) == 0);
      @(posedge clk); model_step(); #1;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL rand_out cyc %0d: got %h want %h", cyc, obs(), expv());
      end
      n_tests++;
      if (ovf_cnt !== exp_ovf()) begin
        n_fail++; $display("FAIL rand_ovf cyc %0d: got %h want %h", cyc, ovf_cnt, exp_ovf());
      end
    end
    in_valid = '0; cfg_clr = 1'b0; cfg_core_en = 2'b11;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_pc = '0; in_npc = '0; in_jal = '0; in_jalr = '0;
    cfg_core_en = 2'b11; cfg_clr = 1'b0;
    m_ptr = 0; m_vld = 1'b0; m_core = 1'b0; m_dat = '0; m_drops = 0;
    for (int c = 0; c < NC; c++) m_ovf[c] = 16'd0;
    test_reset();
    test_single();
    test_alternate();
    test_core1_burst();
    test_overload();
    test_core_en();
    test_clr();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
